led_panel_bcm: RTL
==================

Name: led_panel_bcm

Overview:
- Parametrised HUB75 LED-matrix scan driver, successor to the fixed 64x64 / 4-bit panel driver.
- Holds an internal framebuffer that stores two pixels (upper and lower half) per word.
- Scans rows using binary-coded modulation (BCM) over BIT_DEPTH planes, with an 8-bit global brightness control.
- Runs entirely in the system clock domain using a tick enable, with no derived clock. Sits between the framebuffer writer (image loader or CPU) and the panel connector.

Parameters:
- NUM_COLS, 64, panel columns (power of 2, >=4)
- NUM_ROWS, 64, panel rows (power of 2, >=4); scan rows = NUM_ROWS/2
- BIT_DEPTH, 4, bits per colour channel (1..8)
- CLK_DIV, 3, clk cycles per tick (>=2)
- BASE_DELAY, 50, SHOW ticks for plane 0; plane b lasts BASE_DELAY<<b ticks

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- init  in  1  run enable; scanning runs while high
- brightness  in  8  global on-time scale
- we_a  in  1  framebuffer write enable
- mem_w_address  in  AW  write word address {row[RW-1:0], col}; AW = clog2(NUM_ROWS*NUM_COLS/2), RW = clog2(NUM_ROWS/2)
- mem_w_data  in  6*BIT_DEPTH  {R0,G0,B0,R1,G1,B1}, each BIT_DEPTH bits; R0 is the MSB field
- swap_req  in  1  buffer swap request pulse (feature only)
- LP_CLK  out  1  panel shift clock
- LATCH  out  1  panel latch
- NOE  out  1  output enable, active low
- ROW  out  RW  row address
- RGB0  out  3  {R,G,B} bit of the upper-half pixel
- RGB1  out  3  {R,G,B} bit of the lower-half pixel
- frame_done  out  1  one-clk pulse at end of frame
- busy  out  1  high when FSM is not in IDLE
- swap_pending  out  1  swap requested, not yet applied

Behaviour:
- Ports and state are all in a single clock domain, clk; rst is synchronous and active-high.
- Reset values: LP_CLK=0, LATCH=0, NOE=1, ROW=0, RGB0=RGB1=0, frame_done=0, busy=0, swap_pending=0.
- Reset also clears the tick divider, the row/col/plane/delay counters and the FSM (state IDLE). Framebuffer contents are undefined after reset.
- Reset mid-operation aborts immediately; the next clk shows reset values.
- Tick: divider counts 0..CLK_DIV-1 and asserts tick when it equals CLK_DIV-1. The FSM advances only on tick; outputs are registered.
- Framebuffer: one synchronous read port with 1-clk latency, which always resolves before the next tick because CLK_DIV>=2.
  - Write port: writes on clk when we_a=1. Writes to the displayed buffer take effect immediately, with tearing allowed.
- FSM states:
  - IDLE: NOE=1. If init=1, go to SHIFT with row=0, plane=0, col=0.
  - SHIFT: each column takes 2 ticks.
    - Phase A: LP_CLK=0; drive RGB0/RGB1 from bit [plane] of the word at {row, col}.
    - Phase B: LP_CLK=1.
    - After phase B of col=NUM_COLS-1, go to BLANK.
  - BLANK: 1 tick, NOE=1, LP_CLK=0.
  - LATCH: 1 tick, LATCH=1; ROW<=row on entry.
  - SHOW: lasts BASE_DELAY<<plane ticks.
    - NOE=0 for the first ON ticks, where ON = ((BASE_DELAY<<plane)*(brightness+1))>>8; NOE=1 for the remainder.
    - Plane period is independent of brightness. ON=0 keeps NOE=1 throughout.
  - NEXT: 1 tick, NOE=1.
    - plane++. On plane wrap (BIT_DEPTH-1 -> 0), row++.
    - On row wrap (NUM_ROWS/2-1 -> 0), pulse frame_done for one clk.
    - After a row wrap: go to IDLE if init=0, else SHIFT. Otherwise go to SHIFT.
- init falling mid-frame: the current frame completes, then the FSM enters IDLE.
- Delay counter width = clog2(BASE_DELAY<<(BIT_DEPTH-1))+1. The brightness product uses full width, with no truncation before the shift.

Optional Feature:
- Macro: LED_PANEL_DOUBLE_BUFFER_EN.
- Defined:
  - Two framebuffers, front and back. Display reads front; writes go to back.
  - swap_req sets swap_pending. At the clk where frame_done pulses with swap_pending=1, front/back toggle and swap_pending clears.
  - swap_req coinciding with that frame_done is applied at the next frame boundary.
- Undefined:
  - Single buffer. swap_req is ignored; swap_pending is tied to 0.

Test Plan (NUM_COLS=4, NUM_ROWS=4, BIT_DEPTH=2, CLK_DIV=2, BASE_DELAY=3):
- Reset with init=0 -> NOE=1, LATCH=0, LP_CLK=0, ROW=0, busy=0 held for 50 clk.
- Write word 0 = 12'b11_00_01_10_00_11, then init=1 -> in plane 0 row 0, col 0 shows RGB0=3'b101 and RGB1=3'b001 on the LP_CLK rising edge; 4 LP_CLK pulses per row.
- brightness=255 -> plane 0 NOE low 3 ticks (6 clk) and plane 1 low 6 ticks.
  - brightness=127 -> low 1 and 3 ticks; SHOW period unchanged.
  - brightness=0 -> NOE never low.
- Full frame -> ROW sequence 0,0,1,1 latched; frame_done is one clk high after 2 rows x 2 planes.
- init dropped during row 0 -> row 1 still completes, then IDLE with NOE=1 and busy=0.
- DOUBLE_BUFFER_EN, write back buffer then pulse swap_req mid-frame -> old data displayed until frame_done, new data from the next frame; swap_pending clears at frame_done.

Source files
------------

// File: rtl/led_panel_bcm.sv
// -----------------------------------------------------------------------------
// led_panel_bcm
// HUB75 LED-matrix scan driver. An internal framebuffer holds an upper-half
// and a lower-half pixel in each word. Rows are scanned with binary-coded
// modulation over BIT_DEPTH planes. An 8-bit brightness value scales the
// on-time inside each plane without changing the plane period. Everything
// runs on clk and advances on a divided tick enable. No derived clock is used.
//
// Optional build macro: LED_PANEL_DOUBLE_BUFFER_EN
//   defined   : front/back framebuffers. The display reads front and writes
//               go to back. Buffers swap at a frame boundary after swap_req.
//   undefined : a single framebuffer. swap_req is ignored and swap_pending=0.
// -----------------------------------------------------------------------------
module led_panel_bcm #(
   parameter int  NUM_COLS   = 64,
   parameter int  NUM_ROWS   = 64,
   parameter int  BIT_DEPTH  = 4,
   parameter int  CLK_DIV    = 3,
   parameter int  BASE_DELAY = 50,
   localparam int RW         = $clog2(NUM_ROWS / 2),
   localparam int AW         = $clog2(NUM_ROWS * NUM_COLS / 2),
   localparam int DW         = 6 * BIT_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic [7:0]    brightness,
   input  logic          we_a,
   input  logic [AW-1:0] mem_w_address,
   input  logic [DW-1:0] mem_w_data,
   input  logic          swap_req,
   output logic          LP_CLK,
   output logic          LATCH,
   output logic          NOE,
   output logic [RW-1:0] ROW,
   output logic [2:0]    RGB0,
   output logic [2:0]    RGB1,
   output logic          frame_done,
   output logic          busy,
   output logic          swap_pending
);

   localparam int SCAN_ROWS = NUM_ROWS / 2;
   localparam int CW        = $clog2(NUM_COLS);
   localparam int PW        = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
   localparam int DIVW      = $clog2(CLK_DIV);
   // Wide enough to hold the longest plane period, BASE_DELAY<<(BIT_DEPTH-1).
   localparam int DLW       = $clog2(BASE_DELAY << (BIT_DEPTH - 1)) + 1;
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
   localparam int MAW       = AW + 1;
`else
   localparam int MAW       = AW;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_SHOW,
      S_NEXT
   } state_t;

   state_t           state;
   logic             phase;      // 0: data phase (LP_CLK low), 1: clock phase
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [PW-1:0]    plane;
   logic [DLW-1:0]   dly;

   logic [DIVW-1:0]  div;
   logic             tick;

   logic [DW-1:0]    mem [1 << MAW];
   logic [DW-1:0]    rd_data;
   logic [MAW-1:0]   rd_index;
   logic [MAW-1:0]   wr_index;

   logic [BIT_DEPTH-1:0] r0, g0, b0, r1, g1, b1;
   logic [2:0]       pix0;
   logic [2:0]       pix1;

   logic [DLW-1:0]   period;
   logic [DLW+8:0]   on_prod;
   logic [DLW:0]     on_ticks;
   logic             on_now;
   logic             last_show;
   logic             frame_wrap;

   // Tick divider: counts 0..CLK_DIV-1, and tick marks the last count.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + DIVW'(1);
      end
   end

   assign tick = (div == DIVW'(CLK_DIV - 1));

   // Buffer selection: the display reads front and the writer fills back.
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
   logic front;
   assign rd_index = {front, row, col};
   assign wr_index = {~front, mem_w_address};
`else
   logic unused_swap_req;
   assign unused_swap_req = swap_req;
   assign rd_index        = {row, col};
   assign wr_index        = mem_w_address;
   assign swap_pending    = 1'b0;
`endif

   // Framebuffer: write port plus one synchronous read port (1-clk latency).
   // The read settles before the next tick because CLK_DIV >= 2.
   // NOTE: the memory array is deliberately left out of reset so it maps to
   // block RAM; its contents are undefined until the writer fills it.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[wr_index] <= mem_w_data;
      end
      rd_data <= mem[rd_index];
   end

   // Unpack the word into channels and pick the active bit plane.
   assign {r0, g0, b0, r1, g1, b1} = rd_data;
   assign pix0 = {r0[plane], g0[plane], b0[plane]};
   assign pix1 = {r1[plane], g1[plane], b1[plane]};

   // On-time for this plane. The product is kept at full width before >> 8.
   // NOTE: every always_comb output gets a value on every path (defaults
   // first); a path that skips an output would infer a latch.
   always_comb begin
      period   = DLW'(BASE_DELAY) << plane;
      on_prod  = (DLW + 9)'(period) * (DLW + 9)'({1'b0, brightness} + 9'd1);
      on_ticks = (DLW + 1)'(on_prod >> 8);
      on_now   = ({1'b0, dly} < on_ticks);
      last_show = (dly == period - DLW'(1));
   end

   assign frame_wrap = tick && (state == S_NEXT) &&
                       (plane == PW'(BIT_DEPTH - 1)) &&
                       (row == RW'(SCAN_ROWS - 1));

   // Scan FSM: moves only on tick, and all panel outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         phase      <= 1'b0;
         col        <= '0;
         row        <= '0;
         plane      <= '0;
         dly        <= '0;
         LP_CLK     <= 1'b0;
         LATCH      <= 1'b0;
         NOE        <= 1'b1;
         ROW        <= '0;
         RGB0       <= '0;
         RGB1       <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            unique case (state)
               S_IDLE: begin
                  NOE    <= 1'b1;
                  LP_CLK <= 1'b0;
                  LATCH  <= 1'b0;
                  if (init) begin
                     state <= S_SHIFT;
                     phase <= 1'b0;
                     row   <= '0;
                     col   <= '0;
                     plane <= '0;
                     busy  <= 1'b1;
                  end
               end
               S_SHIFT: begin
                  if (!phase) begin
                     LP_CLK <= 1'b0;
                     RGB0   <= pix0;
                     RGB1   <= pix1;
                     phase  <= 1'b1;
                  end else begin
                     LP_CLK <= 1'b1;
                     phase  <= 1'b0;
                     if (col == CW'(NUM_COLS - 1)) begin
                        col   <= '0;
                        state <= S_BLANK;
                     end else begin
                        col <= col + CW'(1);
                     end
                  end
               end
               S_BLANK: begin
                  NOE    <= 1'b1;
                  LP_CLK <= 1'b0;
                  state  <= S_LATCH;
               end
               S_LATCH: begin
                  LATCH <= 1'b1;
                  ROW   <= row;
                  dly   <= '0;
                  state <= S_SHOW;
               end
               S_SHOW: begin
                  LATCH <= 1'b0;
                  NOE   <= ~on_now;
                  if (last_show) begin
                     state <= S_NEXT;
                  end else begin
                     dly <= dly + DLW'(1);
                  end
               end
               S_NEXT: begin
                  NOE   <= 1'b1;
                  phase <= 1'b0;
                  col   <= '0;
                  state <= S_SHIFT;
                  if (plane == PW'(BIT_DEPTH - 1)) begin
                     plane <= '0;
                     if (row == RW'(SCAN_ROWS - 1)) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                        if (!init) begin
                           state <= S_IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        row <= row + RW'(1);
                     end
                  end else begin
                     plane <= plane + PW'(1);
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef LED_PANEL_DOUBLE_BUFFER_EN
   // Swap control. The toggle happens on the edge that raises frame_done, so
   // the first read of the next frame already comes from the new front.
   always_ff @(posedge clk) begin
      if (rst) begin
         front        <= 1'b0;
         swap_pending <= 1'b0;
      end else if (frame_wrap && swap_pending) begin
         front        <= ~front;
         swap_pending <= swap_req;
      end else if (swap_req) begin
         swap_pending <= 1'b1;
      end
   end
`endif

endmodule
